// File: rtl/run_pkg.sv
// rtl/run_pkg.sv - shared state encoding, halt modes and width helper for run_monitor
package run_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_HOLD = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
    localparam logic [2:0] ST_TOUT     = 3'd4;

    localparam int HALT_ANY = 0;
    localparam int HALT_ALL = 1;

    // Core-index width; a single core still gets a 1-bit id
    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/run_monitor_halt_tracker.sv
// rtl/run_monitor_halt_tracker.sv - sticky per-core halt mask, first-halt encoder, any/all reduce
module halt_tracker #(
    parameter int NUM_CORES = 1,
    parameter int ID_W      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 track,
    input  logic [NUM_CORES-1:0] halt,
    output logic [NUM_CORES-1:0] halt_mask,
    output logic [ID_W-1:0]      first_halt_id,
    output logic                 any_nxt,
    output logic                 all_nxt
);

    logic [NUM_CORES-1:0] mask_nxt;
    logic [ID_W-1:0]      first_idx;

    always_comb begin
        mask_nxt = halt_mask | halt;
        any_nxt  = |mask_nxt;
        all_nxt  = &mask_nxt;
    end

    // Descending scan so the lowest halting index wins
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (halt[i]) first_idx = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            halt_mask     <= '0;
            first_halt_id <= '0;
        end else if (clear) begin
            halt_mask     <= '0;
            first_halt_id <= '0;
        end else if (track) begin
            halt_mask <= mask_nxt;
            if (halt_mask == '0 && halt != '0) first_halt_id <= first_idx;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - CPU run controller: reset sequencing, run timing, halt detect, watchdog
module run_monitor
    import run_pkg::*;
#(
    parameter int NUM_CORES      = 1,
    parameter int RESET_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int CNT_W          = 16,
    parameter int HALT_MODE      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [NUM_CORES-1:0]          halt,
    output logic                          core_reset,
    output logic                          core_en,
    output logic                          running,
    output logic                          done,
    output logic                          timed_out,
    output logic [NUM_CORES-1:0]          halt_mask,
    output logic [id_w(NUM_CORES)-1:0]    first_halt_id,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam int RC_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state, state_nxt;
    logic [RC_W-1:0]  rst_cnt, rst_cnt_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_nxt, tout_nxt;
    logic             clear, track, any_nxt, all_nxt, complete;

    halt_tracker #(
        .NUM_CORES (NUM_CORES),
        .ID_W      (id_w(NUM_CORES))
    ) u_tracker (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .track         (track),
        .halt          (halt),
        .halt_mask     (halt_mask),
        .first_halt_id (first_halt_id),
        .any_nxt       (any_nxt),
        .all_nxt       (all_nxt)
    );

    assign complete = (HALT_MODE == HALT_ALL) ? all_nxt : any_nxt;

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        cnt_nxt     = cycle_count;
        done_nxt    = done;
        tout_nxt    = timed_out;
        clear       = 1'b0;
        track       = 1'b0;
        case (state)
            ST_RST_HOLD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    rst_cnt_nxt = rst_cnt + RC_W'(1);
                    if (rst_cnt == RST_LAST) state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // The abort edge still counts and records halts, so status reflects the whole run
                track   = 1'b1;
                cnt_nxt = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (complete) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else if (TIMEOUT_CYCLES != 0 && cycle_count == TO_LAST) begin
                    state_nxt = ST_TOUT;
                    tout_nxt  = 1'b1;
                end
            end
            ST_IDLE, ST_DONE, ST_TOUT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt   = ST_RST_HOLD;
                    clear       = 1'b1;
                    rst_cnt_nxt = '0;
                    cnt_nxt     = '0;
                    done_nxt    = 1'b0;
                    tout_nxt    = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            running     <= 1'b0;
            core_reset  <= 1'b1;
            core_en     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            cycle_count <= cnt_nxt;
            done        <= done_nxt;
            timed_out   <= tout_nxt;
            running     <= (state_nxt == ST_RUN);
            core_reset  <= (state_nxt == ST_IDLE) || (state_nxt == ST_RST_HOLD);
            core_en     <= (state_nxt == ST_RST_HOLD) || (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// tb/tb_run_monitor.sv - self-checking bench for run_monitor in any-halt and all-halt modes
module tb_run_monitor;

    localparam int T  = 100;
    localparam int RC = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic [3:0] halt = '0;

    logic        a_core_reset, a_core_en, a_running, a_done, a_timed_out;
    logic [3:0]  a_halt_mask;
    logic [1:0]  a_first_halt_id;
    logic [15:0] a_cycle_count;
    logic        l_core_reset, l_core_en, l_running, l_done, l_timed_out;
    logic [3:0]  l_halt_mask;
    logic [1:0]  l_first_halt_id;
    logic [15:0] l_cycle_count;

    run_monitor #(.NUM_CORES(4), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(T), .CNT_W(16), .HALT_MODE(0)) dut_any (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .halt(halt),
        .core_reset(a_core_reset), .core_en(a_core_en), .running(a_running), .done(a_done),
        .timed_out(a_timed_out), .halt_mask(a_halt_mask), .first_halt_id(a_first_halt_id),
        .cycle_count(a_cycle_count)
    );

    run_monitor #(.NUM_CORES(4), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(T), .CNT_W(16), .HALT_MODE(1)) dut_all (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .halt(halt),
        .core_reset(l_core_reset), .core_en(l_core_en), .running(l_running), .done(l_done),
        .timed_out(l_timed_out), .halt_mask(l_halt_mask), .first_halt_id(l_first_halt_id),
        .cycle_count(l_cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        bit         d;
        bit         t;
        bit         ab;
        logic [3:0] m;
        logic [1:0] f;
        int         c;
    } exp_t;

    int         nrun = 0;
    int         nfail = 0;
    logic [3:0] sched [1:T];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nrun++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the halt schedule cycle by cycle and apply the run rules directly
    function automatic exp_t model(input bit all_mode, input int ab);
        exp_t       e;
        logic [3:0] m;
        bit         seen;
        m = '0; seen = 0;
        e.k = T; e.c = T; e.d = 0; e.t = 0; e.ab = 0; e.f = '0; e.m = '0;
        for (int k = 1; k <= T; k++) begin
            if (!seen && sched[k] != 0) begin
                seen = 1;
                for (int i = 3; i >= 0; i--) if (sched[k][i]) e.f = 2'(i);
            end
            m = m | sched[k];
            e.k = k; e.c = k; e.m = m;
            if (k == ab) begin e.ab = 1; return e; end
            if (all_mode ? (m == 4'hF) : (m != 0)) begin e.d = 1; return e; end
        end
        e.t = 1;
        return e;
    endfunction

    task automatic check_reset(input string p);
        check({p, "_a_core_reset"}, a_core_reset, 1);
        check({p, "_a_core_en"}, a_core_en, 0);
        check({p, "_a_running"}, a_running, 0);
        check({p, "_a_done"}, a_done, 0);
        check({p, "_a_timed_out"}, a_timed_out, 0);
        check({p, "_a_mask"}, a_halt_mask, 0);
        check({p, "_a_fid"}, a_first_halt_id, 0);
        check({p, "_a_count"}, a_cycle_count, 0);
        check({p, "_l_core_reset"}, l_core_reset, 1);
        check({p, "_l_count"}, l_cycle_count, 0);
    endtask

    task automatic start_and_hold(input string p);
        int hold = 0;
        int guard = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({p, "_cleared_done"}, {a_done, a_timed_out, l_done, l_timed_out}, 0);
        check({p, "_cleared_count"}, a_cycle_count, 0);
        check({p, "_cleared_mask"}, {a_halt_mask, l_halt_mask}, 0);
        while (!a_running && guard < 20) begin
            if (a_core_reset && a_core_en) hold++;
            @(negedge clk);
            guard++;
        end
        check({p, "_hold_cycles"}, hold, RC);
        check({p, "_run_entered"}, {a_running, l_running, a_core_reset, a_core_en}, 4'b1101);
    endtask

    task automatic check_end(input string p, input int k, input exp_t e, input logic cr, input logic ce,
                             input logic d, input logic t, input logic [3:0] m, input logic [1:0] f,
                             input logic [15:0] c);
        check({p, "_end_cycle"}, k, e.k);
        check({p, "_done"}, d, e.d);
        check({p, "_timed_out"}, t, e.t);
        check({p, "_mask"}, m, e.m);
        check({p, "_first_id"}, f, e.f);
        check({p, "_count"}, c, e.c);
        check({p, "_core_en"}, ce, 0);
        check({p, "_core_reset"}, cr, e.ab);
    endtask

    task automatic do_run(input string p, input int ab);
        exp_t ea, el;
        bit   act_a = 1, act_l = 1;
        int   k = 1;
        ea = model(0, ab);
        el = model(1, ab);
        start_and_hold(p);
        while ((act_a || act_l) && k <= T + 5) begin
            halt  = (k <= T) ? sched[k] : 4'h0;
            abort = (k == ab);
            @(negedge clk);
            abort = 1'b0;
            if (act_a && !a_running) begin
                act_a = 0;
                check_end({p, "_any"}, k, ea, a_core_reset, a_core_en, a_done, a_timed_out,
                          a_halt_mask, a_first_halt_id, a_cycle_count);
            end
            if (act_l && !l_running) begin
                act_l = 0;
                check_end({p, "_all"}, k, el, l_core_reset, l_core_en, l_done, l_timed_out,
                          l_halt_mask, l_first_halt_id, l_cycle_count);
            end
            k++;
        end
        halt = '0;
        check({p, "_both_stopped"}, {act_a, act_l}, 0);
    endtask

    task automatic clear_sched();
        for (int k = 1; k <= T; k++) sched[k] = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset = 1'b1;

        clear_sched();
        for (int k = 37; k <= T; k++) sched[k] = 4'b0001;
        do_run("halt37", 0);

        clear_sched();
        do_run("no_halt", 0);

        clear_sched();
        for (int k = 1; k <= T; k++)
            sched[k] = {k >= 12, k >= 2 && k >= 20, k >= 5, k >= 9};
        do_run("four_core", 0);

        clear_sched();
        sched[T] = 4'hF;
        do_run("halt_at_limit", 0);

        clear_sched();
        sched[3] = 4'b0001; sched[10] = 4'b0010; sched[30] = 4'b0100; sched[60] = 4'b1000;
        do_run("pulses", 0);

        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("start_abort_a", {a_done, a_core_reset, a_running}, 3'b110);
        check("start_abort_a_count", a_cycle_count, 3);
        check("start_abort_l", {l_done, l_core_reset, l_running}, 3'b110);
        check("start_abort_l_count", l_cycle_count, 60);

        clear_sched();
        do_run("abort15", 15);

        start_and_hold("midrst");
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        reset = 1'b1;

        clear_sched();
        sched[40] = 4'b1010;
        do_run("after_rst", 0);

        for (int r = 0; r < 10; r++) begin
            int rise, len, ab;
            clear_sched();
            for (int c = 0; c < 4; c++) begin
                rise = $urandom_range(1, 130);
                len  = ($urandom_range(0, 1) == 0) ? 200 : $urandom_range(1, 40);
                for (int k = rise; k < rise + len && k <= T; k++) sched[k][c] = 1'b1;
            end
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 110) : 0;
            do_run($sformatf("rand%0d", r), ab);
        end

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
